ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends command bytes to the keyboard on the bidirectional PS2Clk/PS2Data lines, e.g. 0xFF reset, 0xED set-LEDs, 0xF4 enable.
- Sits beside the existing PS/2 receive path inside top_vga, in the 65 MHz pixel-clock domain.
- Drives the lines open-drain through output-enable signals; the pad-level tristate (drive 0 when oe=1, else Z) is outside this block.

Parameters:
- CLK_FREQ_HZ, 65_000_000, system clock frequency used to derive cycle counts.
- INHIBIT_US, 100, time clock is held low before the start bit (6500 cycles at default).
- FIRST_EDGE_TIMEOUT_US, 15000, maximum wait from clock release to the first device falling edge.
- BIT_TIMEOUT_US, 2000, maximum gap between successive device falling edges.
- FILTER_LEN, 8, stable-sample count for the optional glitch filter.

Ports:
- clk, input, 1, system clock (65 MHz).
- rst, input, 1, asynchronous active-high reset.
- tx_data, input, 8, byte to send.
- tx_valid, input, 1, request; accepted when tx_valid && tx_ready.
- tx_ready, output, 1, high only in IDLE.
- tx_done, output, 1, one-cycle pulse: byte sent and device ACK seen.
- tx_error, output, 1, one-cycle pulse: timeout or missing ACK.
- ps2_clk_in, input, 1, raw PS2Clk pad level (asynchronous).
- ps2_data_in, input, 1, raw PS2Data pad level (asynchronous).
- ps2_clk_oe, output, 1, 1 = pull PS2Clk low.
- ps2_data_oe, output, 1, 1 = pull PS2Data low.

Behaviour:
- Reset values (asynchronous): state=IDLE, all oe=0, tx_ready=1, tx_done=0, tx_error=0, counters 0.
- A reset during any state releases both lines on the same edge.
- Input synchronisation:
  - ps2_clk_in and ps2_data_in each pass through a 2-FF synchroniser.
  - Falling edge = synchronised clk previous 1, current 0 (fall_tick, one cycle).
- Frame register: {stop=1, parity=~^tx_data (odd), tx_data}, latched on acceptance. Bits shift LSB first.
- IDLE:
  - tx_ready=1.
  - On accept, go to INHIBIT; tx_ready drops the next cycle.
- INHIBIT:
  - clk_oe=1.
  - Count INHIBIT_US*CLK_FREQ_HZ/1e6 cycles, then go to START.
- START:
  - data_oe=1 (start bit 0) for 1 cycle with clk_oe still 1.
  - Then clk_oe=0; go to SEND.
  - Load the timeout counter with the first-edge limit.
- SEND, bit index 0..9 (8 data, parity, stop):
  - On each fall_tick: data_oe = ~frame[idx], then idx++.
  - The stop bit gives data_oe=0 (line released).
  - Every fall_tick reloads the timeout counter with the BIT_TIMEOUT_US limit.
  - After the 10th fall_tick, go to ACK.
- ACK:
  - On the next (11th) fall_tick, sample synchronised data.
  - 0 → go to WAIT_IDLE; 1 → go to ERROR.
- WAIT_IDLE:
  - Wait until synchronised clk=1 and data=1, bounded by the bit timeout.
  - Then pulse tx_done and go to IDLE.
- ERROR:
  - Pulse tx_error, release both lines, go to IDLE.
- Timeout:
  - In START, SEND, ACK and WAIT_IDLE, the counter decrements each cycle.
  - Reaching 0 → go to ERROR.
  - Counter width = clog2 of the largest cycle count (20 bits at defaults).
- A fall_tick in the same cycle the counter expires counts as the edge; no error.
- tx_valid outside IDLE is ignored; no queuing. tx_data is don't-care after acceptance.
- tx_done and tx_error are mutually exclusive; never both set in one cycle.
- Device clocks seen in IDLE (normal keyboard RX traffic) are ignored.

Optional Feature:
- PS2_TX_GLITCH_FILTER_EN defined:
  - After the synchroniser, the clock level changes only after FILTER_LEN consecutive identical samples.
  - Adds FILTER_LEN cycles of edge latency; pulses shorter than FILTER_LEN cycles are rejected.
- Not defined: the 2-FF synchronised level is used directly.

Test Plan:
- Send 0xED, device model clocks at 12.5 kHz and ACKs:
  - clk_oe low for exactly 6500 cycles.
  - Data bits seen on device rising edges are 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once; tx_ready returns high.
- Send 0xF4 and 0x01 → parity 0 in both cases; 0x00 and 0xFF → parity 1; all complete with tx_done.
- Device never clocks after release → tx_error exactly 975000 cycles after clk_oe falls to 0; both oe=0.
- Device omits ACK (data high on the 11th edge) → tx_error pulse, no tx_done.
- rst asserted after the 4th data bit → clk_oe=data_oe=0 and tx_ready=1 in the same cycle; the next 0xFF request completes normally.
- tx_valid pulsed repeatedly while busy → only the first byte is transmitted; exactly one tx_done.
- With PS2_TX_GLITCH_FILTER_EN, a 3-cycle low glitch on ps2_clk_in during SEND → no bit advance; the frame stays correct.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends one byte on device clock edges, checks the ACK.
// Optional clock glitch filter enabled by defining PS2_TX_GLITCH_FILTER_EN.
module ps2_host_tx #(
    parameter int unsigned CLK_FREQ_HZ           = 65_000_000,
    parameter int unsigned INHIBIT_US            = 100,
    parameter int unsigned FIRST_EDGE_TIMEOUT_US = 15000,
    parameter int unsigned BIT_TIMEOUT_US        = 2000,
    parameter int unsigned FILTER_LEN            = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam logic [63:0] INHIBIT_CYC = 64'(INHIBIT_US) * 64'(CLK_FREQ_HZ) / 64'd1_000_000;
    localparam logic [63:0] FIRST_CYC   = 64'(FIRST_EDGE_TIMEOUT_US) * 64'(CLK_FREQ_HZ) / 64'd1_000_000;
    localparam logic [63:0] BIT_CYC     = 64'(BIT_TIMEOUT_US) * 64'(CLK_FREQ_HZ) / 64'd1_000_000;
    localparam logic [63:0] MAX_A       = (INHIBIT_CYC > FIRST_CYC) ? INHIBIT_CYC : FIRST_CYC;
    localparam logic [63:0] MAX_CYC     = (MAX_A > BIT_CYC) ? MAX_A : BIT_CYC;
    localparam int          CNT_W       = $clog2(MAX_CYC + 64'd1);

    // The inhibit load is two short of the cycle count: INHIBIT plus the one START cycle
    // together hold the clock low for exactly INHIBIT_CYC cycles.
    localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYC - 64'd2);
    localparam logic [CNT_W-1:0] FIRST_LOAD   = CNT_W'(FIRST_CYC);
    localparam logic [CNT_W-1:0] BIT_LOAD     = CNT_W'(BIT_CYC);
    localparam logic [CNT_W-1:0] CNT_ZERO     = '0;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE,
        S_ERROR
    } state_t;

    logic clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
    logic clk_lvl, clk_prev_q, fall_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
        end else begin
            clk_s1_q  <= ps2_clk_in;
            clk_s2_q  <= clk_s1_q;
            data_s1_q <= ps2_data_in;
            data_s2_q <= data_s1_q;
        end
    end

`ifdef PS2_TX_GLITCH_FILTER_EN
    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);

    logic [FILT_W-1:0] filt_cnt_q;
    logic              clk_filt_q;

    // The filtered level follows only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_cnt_q <= '0;
            clk_filt_q <= 1'b1;
        end else if (clk_s2_q == clk_filt_q) begin
            filt_cnt_q <= '0;
        end else if (filt_cnt_q == FILT_LAST) begin
            filt_cnt_q <= '0;
            clk_filt_q <= clk_s2_q;
        end else begin
            filt_cnt_q <= filt_cnt_q + FILT_W'(1);
        end
    end

    assign clk_lvl = clk_filt_q;
`else
    assign clk_lvl = clk_s2_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_prev_q <= 1'b1;
        end else begin
            clk_prev_q <= clk_lvl;
        end
    end

    assign fall_tick = clk_prev_q & ~clk_lvl;

    state_t           state_q;
    logic [9:0]       frame_q;
    logic [3:0]       idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic             clk_oe_q, data_oe_q, ready_q, done_q, error_q;
    logic             expire;

    // A fall_tick always wins over an expiring counter.
    assign expire = (cnt_q == CNT_ONE) && !fall_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            frame_q   <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tx_valid && ready_q) begin
                        frame_q  <= {1'b1, ~^tx_data, tx_data};
                        idx_q    <= '0;
                        cnt_q    <= INHIBIT_LOAD;
                        clk_oe_q <= 1'b1;
                        ready_q  <= 1'b0;
                        state_q  <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt_q == CNT_ZERO) begin
                        data_oe_q <= 1'b1;
                        state_q   <= S_START;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_START: begin
                    clk_oe_q <= 1'b0;
                    cnt_q    <= FIRST_LOAD;
                    state_q  <= S_SEND;
                end
                S_SEND: begin
                    if (fall_tick) begin
                        data_oe_q <= ~frame_q[idx_q];
                        cnt_q     <= BIT_LOAD;
                        idx_q     <= idx_q + 4'd1;
                        if (idx_q == 4'd9) begin
                            state_q <= S_ACK;
                        end
                    end else if (expire) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                        error_q   <= 1'b1;
                        state_q   <= S_ERROR;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_ACK: begin
                    if (fall_tick) begin
                        if (!data_s2_q) begin
                            cnt_q   <= BIT_LOAD;
                            state_q <= S_WAIT_IDLE;
                        end else begin
                            data_oe_q <= 1'b0;
                            error_q   <= 1'b1;
                            state_q   <= S_ERROR;
                        end
                    end else if (expire) begin
                        data_oe_q <= 1'b0;
                        error_q   <= 1'b1;
                        state_q   <= S_ERROR;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (clk_lvl && data_s2_q) begin
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (cnt_q == CNT_ONE) begin
                        data_oe_q <= 1'b0;
                        error_q   <= 1'b1;
                        state_q   <= S_ERROR;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_ERROR: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    cnt_q     <= '0;
                    ready_q   <= 1'b1;
                    state_q   <= S_IDLE;
                end
                default: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    ready_q   <= 1'b1;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_ready    = ready_q;
    assign tx_done     = done_q;
    assign tx_error    = error_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device model on the open-drain lines, expected outcomes queued per request
// and compared by an independent monitor whenever tx_done/tx_error appears.
module tb_ps2_host_tx;

    localparam int CLK_HZ   = 2_000_000;
    localparam int INH_US   = 100;
    localparam int FIRST_US = 2000;
    localparam int BIT_US   = 200;
    localparam int INH_CYC   = INH_US * (CLK_HZ / 1_000_000);
    localparam int FIRST_CYC = FIRST_US * (CLK_HZ / 1_000_000);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1, dev_data = 1'b1, glitch_n = 1'b1;

    assign ps2_clk_in  = dev_clk & glitch_n & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .CLK_FREQ_HZ(CLK_HZ),
        .INHIBIT_US(INH_US),
        .FIRST_EDGE_TIMEOUT_US(FIRST_US),
        .BIT_TIMEOUT_US(BIT_US),
        .FILTER_LEN(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_done(tx_done),
        .tx_error(tx_error),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    typedef struct {
        bit         is_err;
        bit         chk_frame;
        logic [10:0] frame;
        logic [7:0] data;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [10:0] cap = '0;
    int          checks = 0, errors = 0, n_pushed = 0, n_results = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference frame as the device sees it on the wire: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] ref_frame(input logic [7:0] d);
        int   ones = 0;
        logic par;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d, 1'b0};
    endfunction

    always @(negedge clk) begin
        if (!rst && (tx_done || tx_error)) begin
            check("done_error_exclusive", {63'd0, tx_done & tx_error}, 64'd0);
            check("pending_txn", {63'd0, sb_q.size() > 0}, 64'd1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                n_results++;
                check("result_is_error", {63'd0, tx_error}, {63'd0, mon_e.is_err});
                if (mon_e.chk_frame) check("frame_bits", {53'd0, cap}, {53'd0, mon_e.frame});
                $display("txn data=%02h result=%s frame=%03h", mon_e.data,
                         tx_error ? "error" : "done", cap);
            end
        end
    end

    // kind: 0 expect done, 1 expect error, 2 no outcome expected (aborted by reset)
    task automatic send(input logic [7:0] d, input int kind, input bit chk);
        int   n = 0;
        exp_t e;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_send", {63'd0, tx_ready}, 64'd1);
        if (kind != 2) begin
            e.is_err    = (kind == 1);
            e.chk_frame = chk;
            e.frame     = ref_frame(d);
            e.data      = d;
            sb_q.push_back(e);
            n_pushed++;
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        check("ready_drops", {63'd0, tx_ready}, 64'd0);
    endtask

    // mode: 0 ACK, 1 no ACK, 2 never clocks, 3 stops after the 4th data bit
    task automatic device(input int mode, input int h, input bit spam, input bit glitch);
        int n = 0;
        while (!ps2_clk_oe && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("inhibit_seen", {63'd0, ps2_clk_oe}, 64'd1);
        n = 0;
        while (ps2_clk_oe && n < INH_CYC + 100) begin
            @(negedge clk);
            n++;
        end
        check("inhibit_len", 64'(n), 64'(INH_CYC));
        if (mode == 2) begin
            n = 0;
            while (!tx_error && n < FIRST_CYC + 100) begin
                @(negedge clk);
                n++;
            end
            check("first_edge_timeout", 64'(n), 64'(FIRST_CYC));
            check("oe_released", {62'd0, ps2_clk_oe, ps2_data_oe}, 64'd0);
            return;
        end
        repeat (h) @(negedge clk);
        cap[0] = ps2_data_in;
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            if (spam) begin
                tx_data  = 8'($urandom);
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                repeat (h - 1) @(negedge clk);
            end else begin
                repeat (h) @(negedge clk);
            end
            dev_clk = 1'b1;
            cap[k]  = ps2_data_in;
            if (mode == 3 && k == 4) return;
            if (glitch && k == 3) begin
                repeat (h / 2) @(negedge clk);
                glitch_n = 1'b0;
                repeat (3) @(negedge clk);
                glitch_n = 1'b1;
                repeat (h - h / 2) @(negedge clk);
            end else begin
                repeat (h) @(negedge clk);
            end
        end
        dev_data = (mode == 0) ? 1'b0 : 1'b1;
        repeat (4) @(negedge clk);
        dev_clk = 1'b0;
        repeat (h) @(negedge clk);
        dev_clk = 1'b1;
        repeat (2) @(negedge clk);
        dev_data = 1'b1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("ready_return", {63'd0, tx_ready}, 64'd1);
        repeat (5) @(negedge clk);
    endtask

    task automatic idle_traffic();
        repeat (3) begin
            dev_clk = 1'b0;
            repeat (12) @(negedge clk);
            dev_clk = 1'b1;
            repeat (12) @(negedge clk);
        end
        check("idle_traffic_ignored", {61'd0, tx_ready, ps2_clk_oe, ps2_data_oe}, 64'd4);
    endtask

    logic [7:0] dir_bytes[5] = '{8'hED, 8'hF4, 8'h01, 8'h00, 8'hFF};

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {59'd0, tx_ready, tx_done, tx_error, ps2_clk_oe, ps2_data_oe}, 64'h10);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        idle_traffic();
        foreach (dir_bytes[i]) begin
            send(dir_bytes[i], 0, 1'b1);
            device(0, 25, 1'b0, 1'b0);
            wait_ready();
        end

        repeat (6) begin
            logic [7:0] d;
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) idle_traffic();
            send(d, 0, 1'b1);
            device(0, int'($urandom_range(15, 40)), 1'b0, 1'b0);
            wait_ready();
        end

        send(8'h5A, 1, 1'b0);
        device(2, 25, 1'b0, 1'b0);
        wait_ready();

        send(8'hA5, 1, 1'b1);
        device(1, 25, 1'b0, 1'b0);
        wait_ready();

        send(8'h3C, 0, 1'b1);
        device(0, 20, 1'b1, 1'b0);
        wait_ready();

`ifdef PS2_TX_GLITCH_FILTER_EN
        send(8'h96, 0, 1'b1);
        device(0, 30, 1'b0, 1'b1);
        wait_ready();
`endif

        send(8'h77, 2, 1'b0);
        device(3, 25, 1'b0, 1'b0);
        #3 rst = 1'b1;
        #1 check("reset_abort", {61'd0, ps2_clk_oe, ps2_data_oe, tx_ready}, 64'd1);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send(8'hFF, 0, 1'b1);
        device(0, 25, 1'b0, 1'b0);
        wait_ready();

        repeat (50) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        check("result_count", 64'(n_results), 64'(n_pushed));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at t=%0t, expected completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
